// File: rtl/row_instr_dispatcher_pkg.sv
// rtl/row_instr_dispatcher_pkg.sv - shared types and widths for the row instruction dispatcher
package row_instr_dispatcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALL,
        WAIT_RET,
        DONE
    } state_t;

    // Width needed to hold the guard count; never narrower than one bit.
    function automatic int guard_width(input int guard);
        return (guard < 1) ? 1 : $clog2(guard + 1);
    endfunction

    localparam int DEFAULT_GUARD = 4;
    localparam int GUARD_CNT_W   = guard_width(DEFAULT_GUARD);
    localparam int TMO_CNT_W     = 32;

endpackage

// File: rtl/row_instr_dispatcher.sv
// rtl/row_instr_dispatcher.sv - drives one fabric row's instruction chain and call/ret handshake
module row_instr_dispatcher
    import row_instr_dispatcher_pkg::*;
#(
    parameter int COLS             = 2,
    parameter int INSTR_DATA_WIDTH = 27,
    parameter int INSTR_ADDR_WIDTH = 4,
    parameter int INSTR_HOPS_WIDTH = 4,
    parameter int GUARD            = DEFAULT_GUARD,
    parameter int TIMEOUT          = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [INSTR_DATA_WIDTH-1:0] s_data,
    input  logic [INSTR_ADDR_WIDTH-1:0] s_addr,
    input  logic [INSTR_HOPS_WIDTH-1:0] s_col,
    input  logic                        s_last,
    output logic [INSTR_DATA_WIDTH-1:0] instr_data_out,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out,
    output logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out,
    output logic                        instr_en_out,
    output logic                        call_out,
    input  logic                        ret_in,
    output logic                        busy,
    output logic                        done,
    output logic                        err_col,
    output logic                        timeout
);

    localparam int GW = guard_width(GUARD);

    state_t               state;
    state_t               next_state;
    logic [GW-1:0]        guard_cnt;
    logic [GW-1:0]        guard_nxt;
    logic [TMO_CNT_W-1:0] tmo_cnt;
    logic [TMO_CNT_W-1:0] tmo_nxt;
    logic                 xfer;
    logic                 col_ok;
    logic                 tmo_hit;
    logic                 tmo_fire;

    // s_ready is only high in IDLE/LOAD, so a transfer implies an accepting state.
    assign xfer    = s_valid & s_ready;
    assign col_ok  = 32'(s_col) < 32'(COLS);
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == 32'(TIMEOUT));

    // Next-state logic: load, one-cycle call, guarded wait for ret, one-cycle done.
    always_comb begin
        next_state = state;
        guard_nxt  = guard_cnt;
        tmo_nxt    = tmo_cnt;
        tmo_fire   = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (xfer) begin
                    next_state = s_last ? CALL : LOAD;
                end
            end
            CALL: begin
                next_state = WAIT_RET;
                guard_nxt  = GW'(GUARD);
                tmo_nxt    = '0;
            end
            WAIT_RET: begin
                tmo_nxt = tmo_cnt + 32'd1;
                if (guard_cnt != '0) begin
                    guard_nxt = guard_cnt - GW'(1);
                end else if (ret_in) begin
                    next_state = DONE;
                end
                // A ret seen on the same cycle as the timeout takes priority.
                if (next_state == WAIT_RET && tmo_hit) begin
                    next_state = IDLE;
                    tmo_fire   = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, counters and the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            guard_cnt      <= '0;
            tmo_cnt        <= '0;
            s_ready        <= 1'b0;
            busy           <= 1'b0;
            instr_data_out <= '0;
            instr_addr_out <= '0;
            instr_hops_out <= '0;
            instr_en_out   <= 1'b0;
            call_out       <= 1'b0;
            done           <= 1'b0;
            err_col        <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            state        <= next_state;
            guard_cnt    <= guard_nxt;
            tmo_cnt      <= tmo_nxt;
            s_ready      <= (next_state == IDLE) || (next_state == LOAD);
            busy         <= (next_state != IDLE);
            instr_en_out <= xfer & col_ok;
            err_col      <= xfer & ~col_ok;
            if (xfer && col_ok) begin
                instr_data_out <= s_data;
                instr_addr_out <= s_addr;
                instr_hops_out <= s_col;
            end
            call_out <= (state == CALL);
            done     <= (state == DONE);
            timeout  <= tmo_fire;
        end
    end

endmodule
